// File: rtl/vec_load_seq.sv
// vec_load_seq: streams bytes from a valid/ready source into a bank of
// NUM_ELEM element registers through a shared data bus and a one-hot load strobe.
// Optional feature macro: VLS_ZERO_FILL_EN zero-fills the elements past len
// before signalling done.
module vec_load_seq #(
  parameter int unsigned NUM_ELEM = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LEN_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   din,
  output logic [NUM_ELEM-1:0] ld,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(NUM_ELEM);

`ifdef VLS_ZERO_FILL_EN
  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t              state, state_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [LEN_W-1:0]    len_q, len_n;
  logic [DATA_W-1:0]   din_n;
  logic [NUM_ELEM-1:0] ld_n;
  logic                busy_n, done_n, err_n;
  logic                last_elem;

  // The source may only present data while streaming elements.
  assign in_ready = (state == LOAD);

  // Final streamed element of this vector.
  assign last_elem = (LEN_W'(idx) == (len_q - LEN_W'(1)));

  // State, index and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      len_q <= '0;
      din   <= '0;
      ld    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      len_q <= len_n;
      din   <= din_n;
      ld    <= ld_n;
      busy  <= busy_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  // Next-state and next-output decode; din holds across bubbles, ld is a single-cycle strobe.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len_q;
    din_n   = din;
    ld_n    = '0;
    done_n  = 1'b0;
    err_n   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if ((len == '0) || (len > LEN_MAX)) begin
            err_n = 1'b1;
          end else begin
            len_n   = len;
            idx_n   = '0;
            state_n = LOAD;
          end
        end
      end

      LOAD: begin
        if (in_valid) begin
          din_n = in_data;
          ld_n  = NUM_ELEM'(1) << idx;
          if (last_elem) begin
`ifdef VLS_ZERO_FILL_EN
            if (len_q == LEN_MAX) begin
              state_n = DONE;
            end else begin
              idx_n   = idx + IDX_W'(1);
              state_n = FILL;
            end
`else
            state_n = DONE;
`endif
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end

`ifdef VLS_ZERO_FILL_EN
      FILL: begin
        din_n = '0;
        ld_n  = NUM_ELEM'(1) << idx;
        if (idx == IDX_W'(NUM_ELEM - 1)) begin
          state_n = DONE;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
`endif

      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // busy covers the done pulse cycle as well as every non-idle state.
    busy_n = (state_n != IDLE) || (state == DONE);
  end

endmodule

// File: tb/tb_vec_load_seq.sv
// Self-checking bench for vec_load_seq: directed steps push expected strobes,
// done and err pulses into scoreboard queues; a monitor pops and compares them.
module tb_vec_load_seq;

  localparam int unsigned NUM_ELEM = 8;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned LEN_W    = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [LEN_W-1:0]    len;
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   din;
  logic [NUM_ELEM-1:0] ld;
  logic                busy;
  logic                done;
  logic                err;

  typedef struct {
    int unsigned         cyc;
    logic [NUM_ELEM-1:0] ld;
    logic [DATA_W-1:0]   din;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned done_q[$];
  int unsigned err_q[$];

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int unsigned m_idx = 0;
  int unsigned last_drv = 0;

  vec_load_seq #(.NUM_ELEM(NUM_ELEM), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (din),
    .ld       (ld),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every strobe, done and err must match the head of its queue.
  always @(posedge clk) begin
    exp_t        e;
    int unsigned c;
    #1;
    if (reset === 1'b1) begin
      if (ld !== '0 || (sb_q.size() != 0 && sb_q[0].cyc == cyc)) begin
        if (sb_q.size() == 0) begin
          chk("ld_unexpected", 32'(ld), 32'(0));
        end else begin
          e = sb_q.pop_front();
          chk("ld_cycle", cyc, e.cyc);
          chk("ld", 32'(ld), 32'(e.ld));
          chk("din", 32'(din), 32'(e.din));
        end
      end
      if (done !== 1'b0 || (done_q.size() != 0 && done_q[0] == cyc)) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'(0));
        end else begin
          c = done_q.pop_front();
          chk("done_cycle", cyc, c);
          chk("done", 32'(done), 32'(1));
        end
      end
      if (err !== 1'b0 || (err_q.size() != 0 && err_q[0] == cyc)) begin
        if (err_q.size() == 0) begin
          chk("err_unexpected", 32'(err), 32'(0));
        end else begin
          c = err_q.pop_front();
          chk("err_cycle", cyc, c);
          chk("err", 32'(err), 32'(1));
        end
      end
    end
  end

  task automatic do_start(input int unsigned l);
    logic legal;
    legal = (l != 0) && (l <= NUM_ELEM);
    start = 1'b1;
    len   = LEN_W'(l);
    if (legal) m_idx = 0;
    else err_q.push_back(cyc + 1);
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(legal));
    chk("in_ready_after_start", 32'(in_ready), 32'(legal));
  endtask

  task automatic send(input logic [DATA_W-1:0] data, input int unsigned gap);
    exp_t e;
    repeat (gap) tick();
    chk("in_ready_load", 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    in_data  = data;
    e.cyc = cyc + 1;
    e.ld  = NUM_ELEM'(1) << m_idx;
    e.din = data;
    sb_q.push_back(e);
    last_drv = cyc;
    m_idx++;
    tick();
    in_valid = 1'b0;
  endtask

  // Queue the tail of a vector (fill strobes, done) and advance to the done cycle.
  task automatic finish_vec(input int unsigned l);
    int unsigned f;
    int unsigned d;
    f = 0;
`ifdef VLS_ZERO_FILL_EN
    for (int unsigned el = l; el < NUM_ELEM; el++) begin
      exp_t e;
      e.cyc = last_drv + 2 + f;
      e.ld  = NUM_ELEM'(1) << el;
      e.din = '0;
      sb_q.push_back(e);
      f++;
    end
`endif
    d = last_drv + 2 + f;
    done_q.push_back(d);
    for (int g = 0; g < 64 && cyc < d; g++) tick();
    chk("busy_at_done", 32'(busy), 32'(1));
  endtask

  task automatic end_idle();
    tick();
    chk("busy_after_done", 32'(busy), 32'(0));
    chk("queues_drained", 32'(sb_q.size() + done_q.size() + err_q.size()), 32'(0));
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    len      = '0;
    in_data  = '0;
    in_valid = 1'b0;
    #1;
    chk("rst_ld", 32'(ld), 32'(0));
    chk("rst_din", 32'(din), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Reset mid-stream: asynchronous clear, no done afterwards.
    do_start(4);
    send(8'h5A, 0);
    send(8'h5B, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_ld", 32'(ld), 32'(0));
    chk("midrst_din", 32'(din), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("postrst_busy", 32'(busy), 32'(0));

    // Full vector, in_valid held high.
    do_start(8);
    for (int unsigned i = 0; i < 8; i++) send(DATA_W'(8'h11 * (i + 1)), 0);
    finish_vec(8);

    // Back-to-back start in the cycle after DONE; bytes separated by bubbles.
    do_start(3);
    send(8'hA0, 0);
    send(8'hA1, 2);
    send(8'hA2, 2);
    finish_vec(3);
    end_idle();

    // Illegal lengths.
    do_start(0);
    tick();
    do_start(9);
    tick();
    chk("illegal_busy", 32'(busy), 32'(0));
    chk("illegal_queues", 32'(err_q.size()), 32'(0));

    // start during LOAD is ignored.
    do_start(2);
    start = 1'b1;
    len   = LEN_W'(5);
    send(8'hC1, 1);
    start = 1'b0;
    send(8'hC2, 0);
    finish_vec(2);
    end_idle();

    // Partial vector, zero fill when enabled.
    do_start(5);
    for (int unsigned i = 0; i < 5; i++) send(DATA_W'(8'h31 + i), 0);
    finish_vec(5);
    end_idle();

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
